// File: rtl/sequenciador_acumulador_if.sv
// Bus between the read-side sequencer, its word memory and the accumulator datapath.
// The slave modport is the sequencer's view; the master modport is the surrounding system.
interface sequenciador_acumulador_if #(
    parameter int TAMANHO = 16,
    parameter int ADDR_W  = 8
);
    logic                Start;
    logic [ADDR_W-1:0]   BaseAddr;
    logic [ADDR_W-1:0]   Count;
    logic [TAMANHO-1:0]  MemData;
    logic [ADDR_W-1:0]   MemAddr;
    logic                MemRead;
    logic [TAMANHO-1:0]  M;
    logic                Load;
    logic                Transfer;
    logic                AccClr_n;
    logic                Busy;
    logic                Done;

    modport slave (
        input  Start, BaseAddr, Count, MemData,
        output MemAddr, MemRead, M, Load, Transfer, AccClr_n, Busy, Done
    );

    modport master (
        output Start, BaseAddr, Count, MemData,
        input  MemAddr, MemRead, M, Load, Transfer, AccClr_n, Busy, Done
    );
endinterface

// File: rtl/sequenciador_acumulador.sv
// Read-side controller: clears the accumulator, streams Count words from BaseAddr,
// and strobes Load/Transfer so one word is summed per clock, then pulses Done.
module sequenciador_acumulador #(
    parameter int TAMANHO = 16,
    parameter int ADDR_W  = 8
) (
    input  logic                         Clock,
    input  logic                         Clear,
    sequenciador_acumulador_if.slave     bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_left;
    logic                r_load;
    logic                r_transfer;
    logic                w_read;
    logic [TAMANHO-1:0]  w_operand;

    assign w_read = (r_state == S_RUN);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_left  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_addr  <= bus.BaseAddr;
                        r_left  <= bus.Count;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_state <= (r_left != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_left <= r_left - ADDR_W'(1);
                    if (r_left == ADDR_W'(1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Last Load is in flight while r_load is high; its Transfer follows next cycle.
                    if (!r_load) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobe pipeline follows the read strobe only, so a trailing Transfer always completes.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_load     <= 1'b0;
            r_transfer <= 1'b0;
        end else begin
            r_load     <= w_read;
            r_transfer <= r_load;
        end
    end

    assign w_operand    = bus.MemData;
    assign bus.M        = w_operand;
    assign bus.MemAddr  = r_addr;
    assign bus.MemRead  = w_read;
    assign bus.Load     = r_load;
    assign bus.Transfer = r_transfer;
    assign bus.AccClr_n = Clear & (r_state != S_CLR);
    assign bus.Busy     = (r_state == S_CLR) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.Done     = (r_state == S_DONE);
endmodule

// File: tb/tb_sequenciador_acumulador.sv
// Bench for sequenciador_acumulador: word memory and accumulator models around the DUT,
// a cycle-timeline reference model compared every cycle, and directed plus random runs.
`timescale 1ns/1ps
module tb_sequenciador_acumulador;
    localparam int TAMANHO = 16;
    localparam int ADDR_W  = 8;

    logic Clock = 1'b0;
    logic Clear = 1'b0;
    always #5 Clock = ~Clock;

    sequenciador_acumulador_if #(.TAMANHO(TAMANHO), .ADDR_W(ADDR_W)) bus ();

    sequenciador_acumulador #(.TAMANHO(TAMANHO), .ADDR_W(ADDR_W)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word memory with one-cycle read latency.
    logic [15:0] mem [256];
    always @(posedge Clock or negedge Clear) begin
        if (!Clear) bus.MemData <= '0;
        else if (bus.MemRead) bus.MemData <= mem[bus.MemAddr];
    end

    // Accumulator datapath: operand register on Load, running sum on Transfer.
    logic [15:0] acc_op, acc_res;
    always @(posedge Clock) begin
        if (!bus.AccClr_n) begin
            acc_op  <= '0;
            acc_res <= '0;
        end else begin
            if (bus.Load) acc_op <= bus.M;
            if (bus.Transfer) acc_res <= acc_res + acc_op;
        end
    end

    // Reference timeline: m_k is the cycle index of the current sequence (1 = CLR), 0 = idle.
    int          m_k = 0;
    int          m_n = 0;
    int          m_dc;
    logic [7:0]  m_base = '0;
    logic [15:0] m_sum = '0;
    logic [7:0]  m_a;
    bit          on, e_read, e_load, e_xfer, e_done, e_busy, e_clrn;

    initial begin
        forever begin
            @(posedge Clock);
            m_dc = (m_n == 0) ? 2 : m_n + 4;
            if (!Clear) begin
                m_k = 0;
            end else if (m_k != 0) begin
                m_k++;
                if (m_k > m_dc) m_k = 0;
            end else if (bus.Start) begin
                m_k    = 1;
                m_n    = int'(bus.Count);
                m_base = bus.BaseAddr;
                m_sum  = '0;
                for (int i = 0; i < m_n; i++) begin
                    m_a   = m_base + 8'(i);
                    m_sum = m_sum + mem[m_a];
                end
            end
            m_dc = (m_n == 0) ? 2 : m_n + 4;
            #1;
            on     = (m_k != 0);
            e_read = on && m_n > 0 && m_k >= 2 && m_k <= m_n + 1;
            e_load = on && m_n > 0 && m_k >= 3 && m_k <= m_n + 2;
            e_xfer = on && m_n > 0 && m_k >= 4 && m_k <= m_n + 3;
            e_done = on && m_k == m_dc;
            e_busy = on && m_k < m_dc;
            e_clrn = Clear && !(on && m_k == 1);
            check("MemRead", 32'(bus.MemRead), 32'(e_read));
            check("Load", 32'(bus.Load), 32'(e_load));
            check("Transfer", 32'(bus.Transfer), 32'(e_xfer));
            check("Done", 32'(bus.Done), 32'(e_done));
            check("Busy", 32'(bus.Busy), 32'(e_busy));
            check("AccClr_n", 32'(bus.AccClr_n), 32'(e_clrn));
            check("M", 32'(bus.M), 32'(bus.MemData));
            if (e_read) begin
                m_a = m_base + 8'(m_k - 2);
                check("MemAddr", 32'(bus.MemAddr), 32'(m_a));
            end
            if (e_done) check("sum", 32'(acc_res), 32'(m_sum));
        end
    end

    task automatic start_run(input logic [7:0] base, input logic [7:0] n);
        @(negedge Clock);
        bus.Start    = 1'b1;
        bus.BaseAddr = base;
        bus.Count    = n;
        @(negedge Clock);
        bus.Start    = 1'b0;
        bus.BaseAddr = 8'($urandom);
        bus.Count    = 8'($urandom);
    endtask

    // Called at the negedge of cycle start_cyc; returns at the negedge of the Done cycle.
    task automatic wait_done(input int start_cyc, input int budget, output int cyc, output int nxfer);
        cyc   = start_cyc;
        nxfer = 0;
        while (!bus.Done && cyc < budget) begin
            if (bus.Transfer) nxfer++;
            @(negedge Clock);
            cyc++;
        end
        check("done_seen", 32'(bus.Done), 32'd1);
    endtask

    int          cyc, nx, ndone, n_r;
    logic [7:0]  b_r;
    logic [15:0] s_loc;
    logic [7:0]  a_loc;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        bus.Start    = 1'b0;
        bus.BaseAddr = '0;
        bus.Count    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

        repeat (3) @(negedge Clock);
        check("rst_MemAddr", 32'(bus.MemAddr), 32'd0);
        check("rst_MemRead", 32'(bus.MemRead), 32'd0);
        check("rst_Load", 32'(bus.Load), 32'd0);
        check("rst_Transfer", 32'(bus.Transfer), 32'd0);
        check("rst_Busy", 32'(bus.Busy), 32'd0);
        check("rst_Done", 32'(bus.Done), 32'd0);
        check("rst_AccClr_n", 32'(bus.AccClr_n), 32'd0);
        Clear = 1'b1;
        @(negedge Clock);

        // Reset then sum 1+2+3+4.
        mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3; mem[8'h13] = 16'd4;
        start_run(8'h10, 8'd4);
        wait_done(1, 20, cyc, nx);
        check("t1_done_cycle", 32'(cyc), 32'd8);
        check("t1_transfers", 32'(nx), 32'd4);
        check("t1_result", 32'(acc_res), 32'd10);

        // Empty run.
        start_run(8'h33, 8'd0);
        check("t2_accclr_cycle1", 32'(bus.AccClr_n), 32'd0);
        wait_done(1, 10, cyc, nx);
        check("t2_done_cycle", 32'(cyc), 32'd2);
        check("t2_transfers", 32'(nx), 32'd0);
        check("t2_result", 32'(acc_res), 32'd0);

        // Address and data wrap.
        mem[8'hFE] = 16'hFFFF; mem[8'hFF] = 16'h0002; mem[8'h00] = 16'h0005;
        start_run(8'hFE, 8'd3);
        wait_done(1, 20, cyc, nx);
        check("t3_done_cycle", 32'(cyc), 32'd7);
        check("t3_result", 32'(acc_res), 32'h0006);

        // Back-to-back with a Start pulse during a busy cycle.
        mem[8'h40] = 16'd5; mem[8'h41] = 16'd7; mem[8'h80] = 16'd9;
        start_run(8'h40, 8'd2);
        @(negedge Clock);
        bus.Start = 1'b1; bus.BaseAddr = 8'h80; bus.Count = 8'd1;
        @(negedge Clock);
        bus.Start = 1'b0;
        wait_done(3, 20, cyc, nx);
        check("t4a_done_cycle", 32'(cyc), 32'd6);
        check("t4a_result", 32'(acc_res), 32'd12);
        start_run(8'h80, 8'd1);
        @(negedge Clock);
        check("t4b_cleared", 32'(acc_res), 32'd0);
        wait_done(2, 20, cyc, nx);
        check("t4b_done_cycle", 32'(cyc), 32'd5);
        check("t4b_result", 32'(acc_res), 32'd9);

        // Start in the DONE cycle is ignored.
        start_run(8'h10, 8'd4);
        wait_done(1, 20, cyc, nx);
        bus.Start = 1'b1; bus.BaseAddr = 8'h00; bus.Count = 8'd5;
        @(negedge Clock);
        bus.Start = 1'b0;
        check("t5_busy_after_done", 32'(bus.Busy), 32'd0);
        check("t5_result_held", 32'(acc_res), 32'd10);

        // Reset in cycle 3 of an 8-word run, then a fresh run.
        start_run(8'h20, 8'd8);
        @(negedge Clock);
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        check("t6_MemRead", 32'(bus.MemRead), 32'd0);
        check("t6_Load", 32'(bus.Load), 32'd0);
        check("t6_Transfer", 32'(bus.Transfer), 32'd0);
        check("t6_Busy", 32'(bus.Busy), 32'd0);
        check("t6_AccClr_n", 32'(bus.AccClr_n), 32'd0);
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge Clock);
            if (bus.Done) ndone++;
        end
        check("t6_no_done", 32'(ndone), 32'd0);
        s_loc = '0;
        for (int i = 0; i < 8; i++) begin
            a_loc = 8'h20 + 8'(i);
            s_loc = s_loc + mem[a_loc];
        end
        start_run(8'h20, 8'd8);
        wait_done(1, 30, cyc, nx);
        check("t6_done_cycle", 32'(cyc), 32'd12);
        check("t6_result", 32'(acc_res), 32'(s_loc));

        // Random runs, including a full-length one.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int r = 0; r < 16; r++) begin
            b_r = 8'($urandom);
            n_r = (r == 7) ? 255 : int'($urandom_range(0, 24));
            start_run(b_r, 8'(n_r));
            wait_done(1, n_r + 10, cyc, nx);
            check("rand_done_cycle", 32'(cyc), 32'((n_r == 0) ? 2 : n_r + 4));
            check("rand_transfers", 32'(nx), 32'(n_r));
            repeat ($urandom_range(0, 2)) @(negedge Clock);
        end

        repeat (3) @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sequenciador_acumulador.md
# sequenciador_acumulador

Read-side controller that feeds the accumulator datapath from a word memory. On a start request it clears the accumulator, streams `Count` consecutive words from memory starting at `BaseAddr`, and drives the accumulator's `Load`/`Transfer` strobes so that one word is summed per clock. It sits between the data memory and the accumulator and reports completion with a one-cycle `Done` pulse.

## Interface
- `TAMANHO`, 16, data word width (memory data and accumulator operand).
- `ADDR_W`, 8, memory address width; also width of `Count`.

- `Clock`  in  1  single system clock, rising edge.
- `Clear`  in  1  asynchronous, active-low reset.
- `Start`  in  1  start request; sampled only in IDLE.
- `BaseAddr`  in  ADDR_W  first word address; latched when `Start` is accepted.
- `Count`  in  ADDR_W  number of words to sum (0..2^ADDR_W-1); latched when `Start` is accepted.
- `MemData`  in  TAMANHO  memory read data, valid the cycle after `MemRead`.
- `MemAddr`  out  ADDR_W  memory read address.
- `MemRead`  out  1  memory read strobe.
- `M`  out  TAMANHO  operand to accumulator; combinational copy of `MemData`.
- `Load`  out  1  accumulator operand-register load strobe.
- `Transfer`  out  1  accumulator result-register update strobe.
- `AccClr_n`  out  1  active-low accumulator clear.
- `Busy`  out  1  sequence in progress.
- `Done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE: `Start`=1 at an edge latches `BaseAddr`/`Count`, next state CLR. `Start` is ignored in all other states.
- CLR: lasts 1 cycle with `AccClr_n`=0.
  - Next state is RUN if `Count`≠0, else DONE.
- RUN: `MemRead`=1 every cycle; `MemAddr` = latched base + i for i = 0..Count-1.
  - The address wraps modulo 2^ADDR_W.
  - Moves to DRAIN after the read with i = Count-1.
- Pipeline: `Load` is `MemRead` delayed 1 cycle; `Transfer` is `Load` delayed 1 cycle.
  - Both delay registers are cleared by `Clear` only. They are not cleared by state changes.
- DRAIN: holds until the last `Transfer` cycle has completed, then DONE.
- DONE: `Done`=1 for exactly 1 cycle, then IDLE. A `Start` in the DONE cycle is ignored.
- `Busy`=1 in CLR, RUN and DRAIN; 0 in IDLE and DONE.
- `AccClr_n` = `Clear` AND NOT(state==CLR). The accumulator is therefore also cleared during system reset.
- Sum arithmetic is the accumulator's. The expected result is Σ words mod 2^TAMANHO.
- `Clear` low at any time, including mid-RUN: asynchronously forces IDLE.
  - The in-flight sequence is abandoned.
  - No `Done` is issued for it.

## Timing
- Reset values: `MemAddr`=0, `MemRead`=0, `Load`=0, `Transfer`=0, `Busy`=0, `Done`=0.
  - `AccClr_n`=0 while `Clear` is low.
  - `M` follows `MemData`.
- Cycle numbering: `Start` accepted at edge E0; cycle k is the period after edge Ek.
- Sequence for N = `Count` ≥ 1:
  - CLR in cycle 1.
  - Reads in cycles 2..N+1.
  - `Load` in cycles 3..N+2.
  - `Transfer` in cycles 4..N+3.
  - `Done` in cycle N+4.
  - `Busy` high in cycles 1..N+3.
- N=0: CLR in cycle 1, `Done` in cycle 2, no `MemRead`/`Load`/`Transfer`.
- Throughput: one word per clock. No bubbles between consecutive words.
- Memory contract: read latency exactly 1 cycle. `MemData` must be stable in the cycle `Load`=1, because it is captured at the end of that cycle.
- The accumulator result is valid from cycle N+4, coincident with `Done`, and remains stable until the next CLR.
- Earliest restart: `Start` sampled in the first IDLE cycle after DONE, i.e. cycle N+5.

## Test plan
- Reset then sum: mem[0x10..0x13] = 1,2,3,4; `BaseAddr`=0x10, `Count`=4.
  - `Done` in cycle 8.
  - Accumulator output = 10.
  - `Busy` high in cycles 1..7.
  - `Transfer` high in cycles 4..7.
- Empty run: `Count`=0.
  - `AccClr_n` low in cycle 1.
  - `Done` in cycle 2.
  - Accumulator output = 0.
  - `MemRead`/`Load`/`Transfer` never asserted.
- Address wrap: TAMANHO=16, ADDR_W=8, `BaseAddr`=0xFE, `Count`=3.
  - Reads at 0xFE, 0xFF, 0x00.
  - With words 0xFFFF, 0x0002, 0x0005 the result is 0x0006 (data wrap).
- Back-to-back: 2 words (5, 7), then `Start` at cycle 7 with 1 word (9).
  - First `Done` in cycle 6, result 12.
  - Second run clears first, final result 9.
  - A `Start` pulse asserted during a busy cycle is ignored.
- Reset mid-operation: drop `Clear` in cycle 3 of an 8-word run.
  - All strobes drop immediately.
  - `AccClr_n`=0 while reset is asserted.
  - No `Done` follows.
  - A fresh run after reset gives the correct sum.
